// File: rtl/array_serializer_if.sv
// Bundle between the upstream array stage, array_serializer and its downstream consumer.
// The slave modport is the serializer's view; master is the side that drives it.
interface array_serializer_if #(
    parameter int N  = 8,
    parameter int DW = 32
);
    localparam int IW = $clog2(N);

    logic          load_i;
    logic [DW-1:0] data_i [N];
    logic [N-1:0]  mask_i;
    logic          out_ready_i;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic [IW-1:0] out_idx_o;
    logic          out_last_o;
    logic          busy_o;
    logic          done_o;
    logic          load_drop_o;

    modport slave (
        input  load_i, data_i, mask_i, out_ready_i,
        output out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o, done_o, load_drop_o
    );

    modport master (
        output load_i, data_i, mask_i, out_ready_i,
        input  out_valid_o, out_data_o, out_idx_o, out_last_o, busy_o, done_o, load_drop_o
    );
endinterface

// File: rtl/array_serializer.sv
// Captures an N-entry array plus enable mask and streams the enabled entries
// as valid/ready beats in ascending index order.
//
// state  | meaning
// IDLE   | waiting for load_i; outputs quiet
// STREAM | presenting captured[idx]; advances on each handshake
// DONE   | one-cycle done_o pulse, then back to IDLE
module array_serializer #(
    parameter int N  = 8,
    parameter int DW = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    array_serializer_if.slave  bus
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t        state_q;
    logic [DW-1:0] data_q [N];
    logic [N-1:0]  mask_q;
    logic [IW-1:0] idx_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          out_last_q;
    logic          busy_q;
    logic          done_q;
    logic          load_drop_q;

    logic [IW-1:0] first_idx;
    logic          first_last;
    logic [IW-1:0] nxt_idx;
    logic          nxt_last;

    function automatic logic [N-1:0] above_of(input logic [IW-1:0] idx);
        above_of = '0;
        for (int k = 0; k < N; k++) begin
            if (k > int'(idx)) above_of[k] = 1'b1;
        end
    endfunction

    // Scans downward so the lowest set bit wins.
    function automatic logic [IW-1:0] lowest_set(input logic [N-1:0] m);
        lowest_set = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (m[k]) lowest_set = IW'(k);
        end
    endfunction

    always_comb begin
        first_idx  = lowest_set(bus.mask_i);
        first_last = (bus.mask_i & above_of(first_idx)) == '0;
        nxt_idx    = lowest_set(mask_q & above_of(idx_q));
        nxt_last   = (mask_q & above_of(nxt_idx)) == '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_drop_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            load_drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.load_i) begin
                        for (int k = 0; k < N; k++) data_q[k] <= bus.data_i[k];
                        mask_q <= bus.mask_i;
                        busy_q <= 1'b1;
                        if (bus.mask_i != '0) begin
                            // First beat is taken straight from the inputs to get one-cycle latency.
                            state_q     <= STREAM;
                            idx_q       <= first_idx;
                            out_valid_q <= 1'b1;
                            out_data_q  <= bus.data_i[first_idx];
                            out_last_q  <= first_last;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    load_drop_q <= bus.load_i;
                    if (out_valid_q && bus.out_ready_i) begin
                        if (out_last_q) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b0;
                            out_data_q  <= '0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            idx_q      <= nxt_idx;
                            out_data_q <= data_q[nxt_idx];
                            out_last_q <= nxt_last;
                        end
                    end
                end
                DONE: begin
                    load_drop_q <= bus.load_i;
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_idx_o   = idx_q;
    assign bus.out_last_o  = out_last_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.load_drop_o = load_drop_q;
endmodule

// File: tb/tb_array_serializer.sv
// Directed bench for array_serializer: full, sparse and empty masks, backpressure,
// dropped loads and mid-stream reset.
module tb_array_serializer;
    logic clk_i;
    logic rst_ni;
    int   n_checks;
    int   n_errors;

    array_serializer_if #(.N(8), .DW(32)) bus ();

    array_serializer #(.N(8), .DW(32)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Entered and left on a negedge while the DUT is in IDLE.
    task automatic transfer(input logic [7:0] m, input logic [31:0] base, input bit rnd, input bit poke);
        int   k;
        int   beats;
        int   exp_cnt;
        int   pend;
        int   cyc;
        logic rdy;
        for (int i = 0; i < 8; i++) bus.data_i[i] = base + 32'(i);
        bus.mask_i      = m;
        bus.load_i      = 1'b1;
        bus.out_ready_i = 1'b1;
        @(negedge clk_i);
        bus.load_i = 1'b0;
        for (int i = 0; i < 8; i++) bus.data_i[i] = 32'hdead_0000 + 32'(i);
        bus.mask_i = ~m;
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) if (m[i]) exp_cnt++;
        if (m == 8'h00) begin
            check_eq("empty_valid", 64'(bus.out_valid_o), 64'd0);
            check_eq("empty_done", 64'(bus.done_o), 64'd1);
            check_eq("empty_busy", 64'(bus.busy_o), 64'd1);
            @(negedge clk_i);
            check_eq("empty_done_end", 64'(bus.done_o), 64'd0);
            check_eq("empty_busy_end", 64'(bus.busy_o), 64'd0);
            return;
        end
        k = 0;
        while (k < 8 && !m[k]) k++;
        beats = 0;
        pend  = 0;
        cyc   = 0;
        while (k < 8 && cyc < 200) begin
            check_eq("beat_valid", 64'(bus.out_valid_o), 64'd1);
            check_eq("beat_idx", 64'(bus.out_idx_o), 64'(k));
            check_eq("beat_data", 64'(bus.out_data_o), 64'(base + 32'(k)));
            check_eq("beat_last", 64'(bus.out_last_o), 64'((m >> (k + 1)) == 8'h00));
            if (pend == 1) begin
                check_eq("load_drop_pulse", 64'(bus.load_drop_o), 64'd1);
                pend = 2;
            end else if (pend == 2) begin
                check_eq("load_drop_end", 64'(bus.load_drop_o), 64'd0);
                pend = 3;
            end
            bus.load_i = 1'b0;
            if (poke && beats == 1 && pend == 0) begin
                bus.load_i = 1'b1;
                bus.mask_i = 8'h01;
                pend = 1;
            end
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready_i = rdy;
            @(negedge clk_i);
            if (rdy) begin
                beats++;
                k++;
                while (k < 8 && !m[k]) k++;
            end
            cyc++;
        end
        bus.load_i      = 1'b0;
        bus.out_ready_i = 1'b1;
        check_eq("stream_timeout", 64'(cyc < 200), 64'd1);
        check_eq("beat_count", 64'(beats), 64'(exp_cnt));
        check_eq("done_pulse", 64'(bus.done_o), 64'd1);
        check_eq("done_valid", 64'(bus.out_valid_o), 64'd0);
        check_eq("done_data", 64'(bus.out_data_o), 64'd0);
        check_eq("done_busy", 64'(bus.busy_o), 64'd1);
        @(negedge clk_i);
        check_eq("idle_done", 64'(bus.done_o), 64'd0);
        check_eq("idle_busy", 64'(bus.busy_o), 64'd0);
        check_eq("idle_valid", 64'(bus.out_valid_o), 64'd0);
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_ni          = 1'b0;
        bus.load_i      = 1'b1;
        bus.mask_i      = 8'hff;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) bus.data_i[i] = 32'h100 + 32'(i);
        repeat (3) @(negedge clk_i);
        check_eq("rst_valid", 64'(bus.out_valid_o), 64'd0);
        check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
        check_eq("rst_done", 64'(bus.done_o), 64'd0);
        check_eq("rst_drop", 64'(bus.load_drop_o), 64'd0);
        check_eq("rst_last", 64'(bus.out_last_o), 64'd0);
        check_eq("rst_idx", 64'(bus.out_idx_o), 64'd0);
        check_eq("rst_data", 64'(bus.out_data_o), 64'd0);
        rst_ni     = 1'b1;
        bus.load_i = 1'b0;
        @(negedge clk_i);
        check_eq("post_rst_busy", 64'(bus.busy_o), 64'd0);

        transfer(8'hff, 32'h100, 1'b0, 1'b0);
        transfer(8'h29, 32'h200, 1'b0, 1'b0);
        transfer(8'h00, 32'h300, 1'b0, 1'b0);
        transfer(8'hb6, 32'h400, 1'b1, 1'b0);
        transfer(8'hff, 32'h500, 1'b1, 1'b0);
        transfer(8'hff, 32'h600, 1'b0, 1'b1);
        transfer(8'h80, 32'h700, 1'b0, 1'b0);

        // Abort after three handshakes of a full-mask stream.
        for (int i = 0; i < 8; i++) bus.data_i[i] = 32'h800 + 32'(i);
        bus.mask_i      = 8'hff;
        bus.load_i      = 1'b1;
        bus.out_ready_i = 1'b1;
        @(negedge clk_i);
        bus.load_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_eq("abort_idx", 64'(bus.out_idx_o), 64'd3);
        rst_ni     = 1'b0;
        bus.load_i = 1'b1;
        @(negedge clk_i);
        check_eq("abort_valid", 64'(bus.out_valid_o), 64'd0);
        check_eq("abort_data", 64'(bus.out_data_o), 64'd0);
        check_eq("abort_busy", 64'(bus.busy_o), 64'd0);
        check_eq("abort_done", 64'(bus.done_o), 64'd0);
        check_eq("abort_drop", 64'(bus.load_drop_o), 64'd0);
        rst_ni     = 1'b1;
        bus.load_i = 1'b0;
        @(negedge clk_i);
        check_eq("after_rst_valid", 64'(bus.out_valid_o), 64'd0);
        check_eq("after_rst_done", 64'(bus.done_o), 64'd0);
        transfer(8'h28, 32'h900, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
